pipeline_sequencer: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Takes decode-stage

---
 rtl/pipeline_sequencer_if.sv | 45 ++++
 rtl/pipeline_sequencer.sv | 153 +++++++++++++++
 tb/tb_pipeline_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Control/status bundle between the pipeline sequencer and the pipeline/cache/hazard logic.
interface pipeline_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned REG_W = 5;

    logic             ihit;
    logic             dhit;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_halt;
    logic             ex_dren;
    logic             ex_regwen;
    logic [REG_W-1:0] ex_rd;
    logic             ex_br_taken;
    logic             mem_dren;
    logic             mem_dwen;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline/cache side: supplies status, consumes enables.
    modport master (
        output ihit, dhit, id_rs, id_rt, id_halt, ex_dren, ex_regwen, ex_rd,
               ex_br_taken, mem_dren, mem_dwen,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, halt_out, stall_cnt, flush_cnt
    );

    // Sequencer side.
    modport slave (
        input  ihit, dhit, id_rs, id_rt, id_halt, ex_dren, ex_regwen, ex_rd,
               ex_br_taken, mem_dren, mem_dwen,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
               idex_flush, halt_out, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables, flushes,
// halt drain and saturating stall/flush perf counters.
module pipeline_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_sequencer_if.slave  bus
);
    localparam int unsigned CTR_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DWAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [CTR_W-1:0] drain_ctr, drain_ctr_nxt;
    logic             halt_q, halt_nxt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic mem_busy, load_use;
    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_flush_c, idex_flush_c;
    logic stall_evt, flush_evt;

    assign mem_busy = (bus.mem_dren | bus.mem_dwen) & ~bus.dhit;
    assign load_use = bus.ex_dren & bus.ex_regwen & (bus.ex_rd != 5'd0) &
                      ((bus.ex_rd == bus.id_rs) | (bus.ex_rd == bus.id_rt));

    // Next-state and per-stage control.
    always_comb begin
        state_nxt     = state;
        drain_ctr_nxt = drain_ctr;
        halt_nxt      = halt_q;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        flush_evt     = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    pc_en_c    = 1'b0;
                    ifid_en_c  = 1'b0;
                    idex_en_c  = 1'b0;
                    exmem_en_c = 1'b0;
                    memwb_en_c = 1'b0;
                    state_nxt  = ST_DWAIT;
                end else if (bus.ex_br_taken) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    flush_evt    = 1'b1;
                end else if (load_use) begin
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                end else if (!bus.ihit) begin
                    pc_en_c      = 1'b0;
                    ifid_flush_c = 1'b1;
                end else if (bus.id_halt) begin
                    pc_en_c       = 1'b0;
                    ifid_flush_c  = 1'b1;
                    drain_ctr_nxt = CTR_W'(DRAIN_CYCLES);
                    state_nxt     = ST_DRAIN;
                end
            end
            ST_DWAIT: begin
                if (bus.dhit) begin
                    state_nxt = ST_RUN;
                end else begin
                    pc_en_c    = 1'b0;
                    ifid_en_c  = 1'b0;
                    idex_en_c  = 1'b0;
                    exmem_en_c = 1'b0;
                    memwb_en_c = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Fetch is frozen; older instructions keep retiring until the count expires.
                pc_en_c      = 1'b0;
                ifid_en_c    = 1'b0;
                ifid_flush_c = 1'b1;
                if (mem_busy) begin
                    idex_en_c  = 1'b0;
                    exmem_en_c = 1'b0;
                    memwb_en_c = 1'b0;
                end else if (drain_ctr == CTR_W'(1)) begin
                    state_nxt = ST_HALTED;
                    halt_nxt  = 1'b1;
                end else begin
                    drain_ctr_nxt = drain_ctr - CTR_W'(1);
                end
            end
            ST_HALTED: begin
                pc_en_c    = 1'b0;
                ifid_en_c  = 1'b0;
                idex_en_c  = 1'b0;
                exmem_en_c = 1'b0;
                memwb_en_c = 1'b0;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign stall_evt = ((state == ST_RUN) | (state == ST_DWAIT)) & ~pc_en_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_ctr <= '0;
            halt_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_ctr <= drain_ctr_nxt;
            halt_q    <= halt_nxt;
        end
    end

    // Saturating perf counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Latch controls are held inactive for as long as reset is asserted.
    assign bus.pc_en      = pc_en_c      & rst_n;
    assign bus.ifid_en    = ifid_en_c    & rst_n;
    assign bus.idex_en    = idex_en_c    & rst_n;
    assign bus.exmem_en   = exmem_en_c   & rst_n;
    assign bus.memwb_en   = memwb_en_c   & rst_n;
    assign bus.ifid_flush = ifid_flush_c & rst_n;
    assign bus.idex_flush = idex_flush_c & rst_n;
    assign bus.halt_out   = halt_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_pipeline_sequencer;
    localparam int unsigned CNT_W = 16;
    localparam int M_RUN = 0, M_DWAIT = 1, M_DRAIN = 2, M_HALTED = 3;
    localparam int SAT = 65535;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipeline_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pipeline_sequencer #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int m_mode, m_left, m_stall, m_flush;
    bit m_halt;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    function automatic logic [6:0] act_ctl();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush};
    endfunction

    function automatic bit m_busy();
        return (bus.mem_dren || bus.mem_dwen) && !bus.dhit;
    endfunction

    function automatic bit m_hazard();
        return bus.ex_dren && bus.ex_regwen && (bus.ex_rd != 0) &&
               (bus.ex_rd == bus.id_rs || bus.ex_rd == bus.id_rt);
    endfunction

    function automatic logic [6:0] model_ctl();
        case (m_mode)
            M_RUN: begin
                if (m_busy())              return 7'b0000000;
                else if (bus.ex_br_taken)  return 7'b1111111;
                else if (m_hazard())       return 7'b0011101;
                else if (!bus.ihit)        return 7'b0111110;
                else if (bus.id_halt)      return 7'b0111110;
                else                       return 7'b1111100;
            end
            M_DWAIT: return bus.dhit ? 7'b1111100 : 7'b0000000;
            M_DRAIN: return m_busy() ? 7'b0000010 : 7'b0011110;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_left = 0; m_stall = 0; m_flush = 0; m_halt = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        logic [6:0] c;
        c = model_ctl();
        if ((m_mode == M_RUN || m_mode == M_DWAIT) && !c[6] && m_stall < SAT) m_stall++;
        if (m_mode == M_RUN && !m_busy() && bus.ex_br_taken && m_flush < SAT) m_flush++;
        case (m_mode)
            M_RUN: begin
                if (m_busy()) m_mode = M_DWAIT;
                else if (!bus.ex_br_taken && !m_hazard() && bus.ihit && bus.id_halt) begin
                    m_mode = M_DRAIN; m_left = 3;
                end
            end
            M_DWAIT: if (bus.dhit) m_mode = M_RUN;
            M_DRAIN: if (!m_busy()) begin
                m_left--;
                if (m_left == 0) begin m_mode = M_HALTED; m_halt = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic idle();
        bus.ihit = 1'b1; bus.dhit = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.id_halt = 1'b0; bus.ex_dren = 1'b0; bus.ex_regwen = 1'b0; bus.ex_rd = 5'd0;
        bus.ex_br_taken = 1'b0; bus.mem_dren = 1'b0; bus.mem_dwen = 1'b0;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step_clk();
        step_clk();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step_clk();
        #1;
        checks++;
        if (act_ctl() !== 7'b0000000) begin
            errors++; $display("FAIL reset_ctl got %b want 0000000", act_ctl());
        end
        checks++;
        if (bus.halt_out !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_regs got halt=%b stall=%0d flush=%0d want 0/0/0",
                               bus.halt_out, bus.stall_cnt, bus.flush_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (act_ctl() !== 7'b1111100) begin
            errors++; $display("FAIL reset_run got %b want 1111100", act_ctl());
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_dren = 1'b1; bus.ex_regwen = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs = 5'd3; bus.id_rt = 5'd5;
        #1;
        checks++;
        if (act_ctl() !== 7'b0011101) begin
            errors++; $display("FAIL load_use_ctl got %b want 0011101", act_ctl());
        end
        step_clk();
        idle();
        #1;
        checks++;
        if (bus.stall_cnt !== 16'd1 || bus.pc_en !== 1'b1) begin
            errors++; $display("FAIL load_use_cnt got stall=%0d pc_en=%b want 1/1", bus.stall_cnt, bus.pc_en);
        end
        bus.ex_dren = 1'b1; bus.ex_regwen = 1'b1; bus.ex_rd = 5'd0; bus.id_rt = 5'd0;
        #1;
        checks++;
        if (act_ctl() !== 7'b1111100) begin
            errors++; $display("FAIL load_use_r0 got %b want 1111100", act_ctl());
        end
        step_clk();
        checks++;
        if (bus.stall_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_r0_cnt got %0d want 1", bus.stall_cnt);
        end
    endtask

    task automatic test_dwait();
        do_reset();
        bus.mem_dren = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (act_ctl() !== 7'b0000000) begin
                errors++; $display("FAIL dwait_stall%0d got %b want 0000000", i, act_ctl());
            end
            step_clk();
        end
        bus.dhit = 1'b1;
        #1;
        checks++;
        if (act_ctl() !== 7'b1111100) begin
            errors++; $display("FAIL dwait_release got %b want 1111100", act_ctl());
        end
        step_clk();
        idle();
        #1;
        checks++;
        if (bus.stall_cnt !== 16'd4 || bus.pc_en !== 1'b1) begin
            errors++; $display("FAIL dwait_cnt got stall=%0d pc_en=%b want 4/1", bus.stall_cnt, bus.pc_en);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        bus.ex_br_taken = 1'b1; bus.ihit = 1'b0; bus.id_halt = 1'b1;
        bus.ex_dren = 1'b1; bus.ex_regwen = 1'b1; bus.ex_rd = 5'd7; bus.id_rs = 5'd7;
        #1;
        checks++;
        if (act_ctl() !== 7'b1111111) begin
            errors++; $display("FAIL branch_ctl got %b want 1111111", act_ctl());
        end
        step_clk();
        idle();
        #1;
        checks++;
        if (bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd0 || bus.pc_en !== 1'b1) begin
            errors++; $display("FAIL branch_cnt got flush=%0d stall=%0d pc_en=%b want 1/0/1",
                               bus.flush_cnt, bus.stall_cnt, bus.pc_en);
        end
    endtask

    task automatic test_halt_drain(input bit with_busy);
        int want;
        want = with_busy ? 4 : 3;
        do_reset();
        bus.id_halt = 1'b1;
        step_clk();
        idle();
        for (int k = 1; k <= want; k++) begin
            if (with_busy && k == 1) begin bus.mem_dren = 1'b1; bus.dhit = 1'b0; end
            #1;
            checks++;
            if (bus.halt_out !== 1'b0) begin
                errors++; $display("FAIL halt_early busy=%0d cyc=%0d got 1 want 0", with_busy, k);
            end
            step_clk();
            idle();
        end
        #1;
        checks++;
        if (bus.halt_out !== 1'b1 || act_ctl() !== 7'b0000000) begin
            errors++; $display("FAIL halt_done busy=%0d got halt=%b ctl=%b want 1/0000000",
                               with_busy, bus.halt_out, act_ctl());
        end
        bus.ex_br_taken = 1'b1;
        step_clk();
        step_clk();
        checks++;
        if (bus.halt_out !== 1'b1 || bus.pc_en !== 1'b0 || bus.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL halt_sticky got halt=%b pc_en=%b flush=%0d want 1/0/0",
                               bus.halt_out, bus.pc_en, bus.flush_cnt);
        end
        idle();
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        bus.ihit = 1'b0;
        step_clk();
        idle();
        bus.ex_br_taken = 1'b1;
        step_clk();
        idle();
        bus.id_halt = 1'b1;
        step_clk();
        idle();
        step_clk();
        #1;
        checks++;
        if (bus.stall_cnt !== 16'd2 || bus.flush_cnt !== 16'd1 || bus.pc_en !== 1'b0) begin
            errors++; $display("FAIL pre_reset got stall=%0d flush=%0d pc_en=%b want 2/1/0",
                               bus.stall_cnt, bus.flush_cnt, bus.pc_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (act_ctl() !== 7'b0000000 || bus.halt_out !== 1'b0 ||
            bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL drain_reset got ctl=%b halt=%b stall=%0d flush=%0d want 0/0/0/0",
                               act_ctl(), bus.halt_out, bus.stall_cnt, bus.flush_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (act_ctl() !== 7'b1111100) begin
            errors++; $display("FAIL drain_reset_run got %b want 1111100", act_ctl());
        end
        step_clk();
        step_clk();
        checks++;
        if (bus.halt_out !== 1'b0) begin
            errors++; $display("FAIL drain_reset_nohalt got 1 want 0");
        end
    endtask

    task automatic test_random();
        logic [6:0] exp_c;
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            if ((m_mode == M_HALTED && $urandom_range(3) == 0) || $urandom_range(299) == 0) begin
                idle();
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                model_reset();
            end
            bus.ihit        = ($urandom_range(7) != 0);
            bus.dhit        = ($urandom_range(2) == 0);
            bus.mem_dren    = ($urandom_range(5) == 0);
            bus.mem_dwen    = ($urandom_range(9) == 0);
            bus.ex_br_taken = ($urandom_range(9) == 0);
            bus.ex_dren     = ($urandom_range(2) == 0);
            bus.ex_regwen   = ($urandom_range(1) == 0);
            bus.ex_rd       = 5'($urandom_range(3));
            bus.id_rs       = 5'($urandom_range(3));
            bus.id_rt       = 5'($urandom_range(3));
            bus.id_halt     = ($urandom_range(39) == 0);
            #1;
            exp_c = model_ctl();
            checks++;
            if (act_ctl() !== exp_c) begin
                errors++; $display("FAIL rand_ctl n=%0d mode=%0d got %b want %b", n, m_mode, act_ctl(), exp_c);
            end
            checks++;
            if (bus.halt_out !== m_halt || int'(bus.stall_cnt) != m_stall || int'(bus.flush_cnt) != m_flush) begin
                errors++; $display("FAIL rand_regs n=%0d got halt=%b stall=%0d flush=%0d want %0d/%0d/%0d",
                                   n, bus.halt_out, bus.stall_cnt, bus.flush_cnt, m_halt, m_stall, m_flush);
            end
            model_step();
            step_clk();
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.ihit = 1'b0;
        repeat (65534) @(posedge clk);
        #2;
        checks++;
        if (bus.stall_cnt !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre got %h want fffe", bus.stall_cnt);
        end
        step_clk();
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_reach got %h want ffff", bus.stall_cnt);
        end
        repeat (5) step_clk();
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got %h want ffff", bus.stall_cnt);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_dwait();
        test_branch_priority();
        test_halt_drain(1'b0);
        test_halt_drain(1'b1);
        test_reset_in_drain();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
